// File: rtl/draw_if.sv
// draw_if: request/rectangle bus from the game-object clients and pixel stream toward the VGA adapter.
interface draw_if;
   logic [3:0]  req;
   logic [31:0] rect_x;
   logic [27:0] rect_y;
   logic [31:0] rect_w;
   logic [27:0] rect_h;
   logic [11:0] rect_colour;
   logic [3:0]  grant;
   logic [3:0]  done;
   logic        busy;
   logic [7:0]  x_out;
   logic [6:0]  y_out;
   logic [2:0]  colour_out;
   logic        plot;
   modport master (output req, rect_x, rect_y, rect_w, rect_h, rect_colour,
                   input grant, done, busy, x_out, y_out, colour_out, plot);
   modport slave  (input req, rect_x, rect_y, rect_w, rect_h, rect_colour,
                   output grant, done, busy, x_out, y_out, colour_out, plot);
endinterface

// File: rtl/draw_arbiter.sv
// draw_arbiter: round-robin share of one rectangle rasterizer among four clients, one pixel per cycle.
module draw_arbiter (
   input logic  clock,
   input logic  reset_n,
   draw_if.slave bus
);
   typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
   state_t      state, state_n;
   logic [1:0]  ptr, ptr_n, wi, wi_n, pick;
   logic [7:0]  lx, lx_n, lw, lw_n, xc, xc_n, x_n;
   logic [6:0]  ly, ly_n, lh, lh_n, yc, yc_n, y_n;
   logic [2:0]  lc, lc_n, c_n;
   logic [3:0]  grant_n, done_n;
   logic        plot_n, row_end, last;

   assign row_end  = xc == lw;
   assign last     = row_end && yc == lh;
   assign bus.busy = state != IDLE;

   // Lowest offset from ptr wins, so scan offsets from high to low.
   always_comb begin
      pick = ptr;
      for (int i = 3; i >= 0; i--)
         if (bus.req[ptr + 2'(i)]) pick = ptr + 2'(i);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state          <= IDLE;
         ptr            <= '0;
         wi             <= '0;
         lx             <= '0;
         ly             <= '0;
         lw             <= '0;
         lh             <= '0;
         lc             <= '0;
         xc             <= '0;
         yc             <= '0;
         bus.grant      <= '0;
         bus.done       <= '0;
         bus.plot       <= 1'b0;
         bus.x_out      <= '0;
         bus.y_out      <= '0;
         bus.colour_out <= '0;
      end else begin
         state          <= state_n;
         ptr            <= ptr_n;
         wi             <= wi_n;
         lx             <= lx_n;
         ly             <= ly_n;
         lw             <= lw_n;
         lh             <= lh_n;
         lc             <= lc_n;
         xc             <= xc_n;
         yc             <= yc_n;
         bus.grant      <= grant_n;
         bus.done       <= done_n;
         bus.plot       <= plot_n;
         bus.x_out      <= x_n;
         bus.y_out      <= y_n;
         bus.colour_out <= c_n;
      end
   end

   always_comb
      state_n = state == IDLE ? (|bus.req ? DRAW : IDLE) :
                state == DRAW ? (last ? DONE : DRAW) : IDLE;

   // Next pixel is computed a cycle ahead so x_out/y_out leave straight from flops.
   always_comb begin
      ptr_n   = ptr;
      wi_n    = wi;
      lx_n    = lx;
      ly_n    = ly;
      lw_n    = lw;
      lh_n    = lh;
      lc_n    = lc;
      xc_n    = xc;
      yc_n    = yc;
      x_n     = bus.x_out;
      y_n     = bus.y_out;
      c_n     = bus.colour_out;
      grant_n = bus.grant;
      done_n  = '0;
      plot_n  = 1'b0;
      if (state == IDLE && |bus.req) begin
         wi_n    = pick;
         lx_n    = bus.rect_x[8*pick +: 8];
         ly_n    = bus.rect_y[7*pick +: 7];
         lw_n    = bus.rect_w[8*pick +: 8];
         lh_n    = bus.rect_h[7*pick +: 7];
         lc_n    = bus.rect_colour[3*pick +: 3];
         xc_n    = '0;
         yc_n    = '0;
         x_n     = lx_n;
         y_n     = ly_n;
         c_n     = lc_n;
         grant_n = 4'b0001 << pick;
         plot_n  = 1'b1;
      end else if (state == DRAW) begin
         if (last) done_n = bus.grant;
         else begin
            xc_n   = row_end ? '0 : xc + 8'd1;
            yc_n   = row_end ? yc + 7'd1 : yc;
            x_n    = lx + xc_n;
            y_n    = ly + yc_n;
            plot_n = 1'b1;
         end
      end else if (state == DONE) begin
         ptr_n   = wi + 2'd1;
         grant_n = '0;
      end
   end
endmodule

// File: tb/tb_draw_arbiter.sv
// tb_draw_arbiter: directed stimulus with a pixel/done scoreboard for draw_arbiter.
module tb_draw_arbiter;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   draw_if bus ();
   draw_arbiter dut (.clock(clock), .reset_n(reset_n), .bus(bus));

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
      logic [3:0] g;
   } pix_t;

   pix_t       pq[$];
   logic [3:0] dq[$];
   pix_t       e;
   logic [3:0] ed;
   int         checks = 0;
   int         passes = 0;
   int         busy_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic set_client(input int i, input int x, input int y, input int w, input int h, input int c);
      bus.rect_x[8*i +: 8]      = 8'(x);
      bus.rect_y[7*i +: 7]      = 7'(y);
      bus.rect_w[8*i +: 8]      = 8'(w);
      bus.rect_h[7*i +: 7]      = 7'(h);
      bus.rect_colour[3*i +: 3] = 3'(c);
   endtask

   // Reference raster: row by row, coordinates wrap at 8/7 bits.
   task automatic expect_rect(input int i, input int x, input int y, input int w, input int h, input int c);
      for (int yy = 0; yy <= h; yy++)
         for (int xx = 0; xx <= w; xx++)
            pq.push_back({8'(x + xx), 7'(y + yy), 3'(c), 4'(1 << i)});
      dq.push_back(4'(1 << i));
   endtask

   task automatic drain(input string tag);
      for (int n = 0; n < 200 && (pq.size() != 0 || dq.size() != 0 || bus.busy); n++) @(negedge clock);
      check(tag, pq.size() + dq.size(), 0);
   endtask

   task automatic wait_grant(input string tag, input logic [3:0] g);
      for (int n = 0; n < 100 && bus.grant !== g; n++) @(negedge clock);
      check(tag, 32'(bus.grant), 32'(g));
   endtask

   always @(negedge clock) begin
      if (bus.plot === 1'b1) begin
         check("pixel_expected", 32'(pq.size() != 0), 1);
         if (pq.size() != 0) begin
            e = pq.pop_front();
            check("pixel", {bus.x_out, bus.y_out, bus.colour_out, bus.grant}, e);
         end
      end
      if ((|bus.done) === 1'b1) begin
         check("done_expected", 32'(dq.size() != 0), 1);
         if (dq.size() != 0) begin
            ed = dq.pop_front();
            check("done", 32'(bus.done), 32'(ed));
         end
      end
   end

   initial begin
      bus.req = '0;
      bus.rect_x = '0;
      bus.rect_y = '0;
      bus.rect_w = '0;
      bus.rect_h = '0;
      bus.rect_colour = '0;
      step(3);
      check("rst_grant", 32'(bus.grant), 0);
      check("rst_done", 32'(bus.done), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_plot", 32'(bus.plot), 0);
      check("rst_x", 32'(bus.x_out), 0);
      check("rst_y", 32'(bus.y_out), 0);
      check("rst_colour", 32'(bus.colour_out), 0);
      reset_n = 1'b1;

      set_client(0, 5, 7, 0, 0, 4);
      expect_rect(0, 5, 7, 0, 0, 4);
      bus.req = 4'b0001;
      step(1);
      bus.req = '0;
      check("min_grant", 32'(bus.grant), 1);
      check("min_busy", 32'(bus.busy), 1);
      step(1);
      check("min_done", 32'(bus.done), 1);
      check("min_grant_done", 32'(bus.grant), 1);
      check("min_plot_done", 32'(bus.plot), 0);
      check("min_hold_x", 32'(bus.x_out), 5);
      step(1);
      check("min_grant_idle", 32'(bus.grant), 0);
      check("min_busy_idle", 32'(bus.busy), 0);

      set_client(0, 0, 0, 4, 4, 3);
      expect_rect(0, 0, 0, 4, 4, 3);
      bus.req = 4'b0001;
      busy_cnt = 0;
      for (int n = 0; n < 40; n++) begin
         step(1);
         if (n == 0) bus.req = '0;
         busy_cnt += int'(bus.busy);
      end
      check("sq_busy_cycles", busy_cnt, 26);
      drain("sq_drain");

      reset_n = 1'b0;
      step(1);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) set_client(i, 10 * i + 1, 5 * i + 2, 0, 0, i + 1);
      expect_rect(0, 1, 2, 0, 0, 1);
      expect_rect(1, 11, 7, 0, 0, 2);
      expect_rect(2, 21, 12, 0, 0, 3);
      expect_rect(3, 31, 17, 0, 0, 4);
      expect_rect(0, 1, 2, 0, 0, 1);
      bus.req = 4'b1111;
      for (int n = 1; n <= 15; n++) begin
         step(1);
         if (n == 13) bus.req = '0;
         check("rr_grant", 32'(bus.grant), n % 3 == 0 ? 0 : 1 << (((n - 1) / 3) % 4));
      end
      drain("rr_drain");

      set_client(0, 10, 10, 2, 2, 5);
      set_client(1, 20, 20, 0, 0, 2);
      expect_rect(0, 10, 10, 2, 2, 5);
      expect_rect(1, 20, 20, 0, 0, 2);
      bus.req = 4'b0001;
      step(1);
      bus.rect_x[7:0] = 8'd50;
      bus.req = 4'b0010;
      wait_grant("mid_next_grant", 4'b0010);
      bus.req = '0;
      drain("mid_drain");

      set_client(0, 0, 0, 4, 4, 1);
      expect_rect(0, 0, 0, 4, 4, 1);
      bus.req = 4'b0001;
      step(1);
      bus.req = '0;
      step(9);
      reset_n = 1'b0;
      step(1);
      check("mrst_plot", 32'(bus.plot), 0);
      check("mrst_grant", 32'(bus.grant), 0);
      check("mrst_done", 32'(bus.done), 0);
      check("mrst_busy", 32'(bus.busy), 0);
      check("mrst_x", 32'(bus.x_out), 0);
      check("mrst_y", 32'(bus.y_out), 0);
      check("mrst_pixels_left", pq.size(), 15);
      check("mrst_done_left", dq.size(), 1);
      pq.delete();
      dq.delete();
      reset_n = 1'b1;
      set_client(0, 1, 2, 0, 0, 7);
      set_client(2, 30, 40, 0, 0, 6);
      expect_rect(0, 1, 2, 0, 0, 7);
      expect_rect(2, 30, 40, 0, 0, 6);
      bus.req = 4'b0101;
      step(1);
      check("mrst_first_grant", 32'(bus.grant), 1);
      wait_grant("mrst_second_grant", 4'b0100);
      bus.req = '0;
      drain("mrst_drain");

      set_client(3, 254, 127, 3, 1, 6);
      expect_rect(3, 254, 127, 3, 1, 6);
      bus.req = 4'b1000;
      step(1);
      bus.req = '0;
      check("wrap_first_x", 32'(bus.x_out), 254);
      drain("wrap_drain");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
